// File: rtl/timer_set_multi.sv
// Three-field (h:m:s) settable timer with edge-detected stepping, press-and-hold
// auto-repeat, optional set-mode carry/borrow and a countdown run mode.
module timer_set_multi #(
  parameter int unsigned VAL_W     = 7,
  parameter int unsigned SEC_MOD   = 60,
  parameter int unsigned MIN_MOD   = 60,
  parameter int unsigned HOUR_MOD  = 24,
  parameter logic [3:0]  SEL_SEC   = 4'b0110,
  parameter logic [3:0]  SEL_MIN   = 4'b0111,
  parameter logic [3:0]  SEL_HOUR  = 4'b1000,
  parameter bit          REPEAT_EN = 1'b1,
  parameter int unsigned HOLD_CYC  = 500000,
  parameter int unsigned REP_CYC   = 100000,
  parameter bit          CARRY_EN  = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             U,
  input  logic             D,
  input  logic [3:0]       COUNT,
  input  logic             START,
  input  logic             TICK,
  output logic [VAL_W-1:0] SEC_A,
  output logic [VAL_W-1:0] MIN_A,
  output logic [VAL_W-1:0] HOUR_A,
  output logic             RUN,
  output logic             DONE
);

  localparam logic [1:0] ST_SET  = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned CNT_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  // Modular step of one field; any out-of-range value increments to zero.
  function automatic logic [VAL_W-1:0] step_val(input logic [VAL_W-1:0] v,
                                                input int unsigned m,
                                                input logic up);
    if (up) step_val = (32'(v) >= m - 1) ? '0 : v + VAL_W'(1);
    else    step_val = (v == '0) ? VAL_W'(m - 1) : v - VAL_W'(1);
  endfunction

  function automatic logic wraps(input logic [VAL_W-1:0] v,
                                 input int unsigned m,
                                 input logic up);
    wraps = up ? (32'(v) >= m - 1) : (v == '0);
  endfunction

  logic [1:0]             state_q, state_d;
  logic [VAL_W-1:0]       sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic                   run_q, run_d, done_q, done_d;
  logic [1:0]             last_q, last_d;
  logic [1:0]             ev_q, ev_d;
  logic [1:0]             ph_q, ph_d;
  logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]             btn;
  logic                   up_s, dn_s, nz;

  assign btn = {D, U};

  // Press-edge detection plus hold/repeat timing; index 0 = up, 1 = down.
  always_comb begin
    last_d = btn;
    ev_d   = '0;
    ph_d   = '0;
    cnt_d  = '0;
    for (int i = 0; i < 2; i++) begin
      ev_d[i] = btn[i] & ~last_q[i];
      if (REPEAT_EN && btn[i] && (state_q != ST_RUN)) begin
        ph_d[i]  = ph_q[i];
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        if (!ph_q[i] && (cnt_q[i] == CNT_W'(HOLD_CYC))) begin
          ev_d[i]  = 1'b1;
          ph_d[i]  = 1'b1;
          cnt_d[i] = CNT_W'(1);
        end else if (ph_q[i] && (cnt_q[i] == CNT_W'(REP_CYC))) begin
          ev_d[i]  = 1'b1;
          cnt_d[i] = CNT_W'(1);
        end
      end
    end
  end

  assign up_s = ev_q[0] & ~ev_q[1];
  assign dn_s = ev_q[1] & ~ev_q[0];
  assign nz   = (sec_q != '0) || (min_q != '0) || (hour_q != '0);

  // Next-state and field update.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    case (state_q)
      ST_SET: begin
        if (START && nz) state_d = ST_RUN;
        if (up_s || dn_s) begin
          if (COUNT == SEL_SEC) begin
            sec_d = step_val(sec_q, SEC_MOD, up_s);
            if (CARRY_EN && wraps(sec_q, SEC_MOD, up_s)) begin
              min_d = step_val(min_q, MIN_MOD, up_s);
              if (wraps(min_q, MIN_MOD, up_s)) hour_d = step_val(hour_q, HOUR_MOD, up_s);
            end
          end else if (COUNT == SEL_MIN) begin
            min_d = step_val(min_q, MIN_MOD, up_s);
            if (CARRY_EN && wraps(min_q, MIN_MOD, up_s))
              hour_d = step_val(hour_q, HOUR_MOD, up_s);
          end else if (COUNT == SEL_HOUR) begin
            hour_d = step_val(hour_q, HOUR_MOD, up_s);
          end
        end
      end
      ST_RUN: begin
        if (START) begin
          state_d = ST_SET;
        end else if (TICK) begin
          sec_d = step_val(sec_q, SEC_MOD, 1'b0);
          if (sec_q == '0) begin
            min_d = step_val(min_q, MIN_MOD, 1'b0);
            if (min_q == '0) hour_d = step_val(hour_q, HOUR_MOD, 1'b0);
          end
          if ((sec_d == '0) && (min_d == '0) && (hour_d == '0)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (START || (ev_q != '0)) state_d = ST_SET;
      end
      default: state_d = ST_SET;
    endcase
    run_d  = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_SET;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= '0;
      ev_q    <= '0;
      ph_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      run_q   <= run_d;
      done_q  <= done_d;
      last_q  <= last_d;
      ev_q    <= ev_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
    end
  end

  assign SEC_A  = sec_q;
  assign MIN_A  = min_q;
  assign HOUR_A = hour_q;
  assign RUN    = run_q;
  assign DONE   = done_q;

endmodule

// File: doc/timer_set_multi.md
Name: timer_set_multi

Overview:
- Parametrised successor of the two-field timer-setting block: three settable fields (seconds, minutes, hours), each with its own modulus.
- Adds press-and-hold auto-repeat, optional carry/borrow between fields while setting, and a countdown run mode with a DONE flag.
- Sits between the debounced push-button/mode-select logic and the 7-segment display/alarm logic.

Parameters:
- VAL_W, 7, width of each field output
- SEC_MOD, 60, seconds modulus (legal values 0..SEC_MOD-1)
- MIN_MOD, 60, minutes modulus
- HOUR_MOD, 24, hours modulus
- SEL_SEC, 4'b0110, COUNT code selecting seconds
- SEL_MIN, 4'b0111, COUNT code selecting minutes
- SEL_HOUR, 4'b1000, COUNT code selecting hours
- REPEAT_EN, 1, enables auto-repeat while U/D is held
- HOLD_CYC, 500000, held cycles before the first repeat step
- REP_CYC, 100000, cycles between subsequent repeat steps
- CARRY_EN, 0, 1 = a set-mode wrap carries/borrows into the next field

Ports:
- CLK  in  1  system clock, all logic on the rising edge
- RESET  in  1  synchronous, active-high reset
- U  in  1  debounced up button, level
- D  in  1  debounced down button, level
- COUNT  in  4  mode select; only SEL_* codes allow edits
- START  in  1  single-cycle pulse: start or pause the countdown
- TICK  in  1  single-cycle 1 Hz strobe
- SEC_A  out  VAL_W  seconds value
- MIN_A  out  VAL_W  minutes value
- HOUR_A  out  VAL_W  hours value
- RUN  out  1  high while counting down
- DONE  out  1  high in the DONE state

Behaviour:
- Reset, sampled on a CLK edge with RESET=1: SEC_A=MIN_A=HOUR_A=0, state=SET, RUN=0, DONE=0, U_LAST=D_LAST=0, repeat counters=0. RESET has priority over every other input.
- Edge detect: U_LAST/D_LAST register U/D each cycle. A press event (U & ~U_LAST) is registered into U_EN; D_EN is produced the same way.
  - If U is first sampled high at edge k, the field updates at edge k+1 (one-cycle latency).
- Auto-repeat (REPEAT_EN=1):
  - A per-button hold counter runs while the button stays high and clears when it is low.
  - Extra steps occur at edges k+1+HOLD_CYC, then every REP_CYC cycles after that, until release.
  - With REPEAT_EN=0, only the press edge produces a step.
- Step target: the field selected by COUNT at the cycle the step is applied. Any other COUNT code means no change.
- Simultaneous up and down steps in the same cycle: no change.
- Increment wrap: MOD-1 -> 0. Any value >= MOD is treated as wrapping and increments to 0.
- Decrement wrap: 0 -> MOD-1.
- CARRY_EN=1, set mode only:
  - Seconds wrap on increment increments minutes (with minutes' own wrap); minutes wrap increments hours.
  - Decrement wraps borrow the same way.
  - Hours wrap has no further carry.
- FSM states: SET, RUN, DONE.
  - SET: steps are applied.
    - START with all fields 0: stays in SET.
    - START with any field non-zero: goes to RUN; RUN=1 from the next cycle.
  - RUN: steps are ignored and the repeat counters are held at 0.
    - Each TICK decrements with borrow: sec 0 -> SEC_MOD-1 and borrow from minutes; min 0 -> MIN_MOD-1 and borrow from hours.
    - If a TICK leaves all fields 0, go to DONE in the same edge.
    - START goes to SET (pause) with values retained. START has priority over a coincident TICK, so no decrement occurs.
    - A COUNT change has no effect.
  - DONE: DONE=1, RUN=0, values stay 0. START or any U/D press event returns to SET without stepping any field.
- The field being stepped is selected by COUNT only; the FSM never alters COUNT semantics.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then COUNT=SEL_SEC, one U pulse (U high 3 cycles) -> SEC_A=1 exactly one cycle after the first sampled-high edge, no further change. RESET asserted mid-hold -> all outputs 0 next edge.
- SEC_A=59, U press -> SEC_A=0, MIN_A unchanged (CARRY_EN=0). Same case with CARRY_EN=1 -> SEC_A=0, MIN_A=1. HOUR_A=0 with D press under SEL_HOUR -> HOUR_A=23.
- HOLD_CYC=4, REP_CYC=2, U held 12 cycles under SEL_MIN from 0 -> steps at k+1, k+5, k+7, k+9, k+11, giving MIN_A=5. U and D pressed in the same cycle -> no change.
- Set 0:1:05 (h:m:s), START -> RUN=1. 65 TICKs -> all fields 0, DONE=1, RUN=0. U press -> DONE=0, SEC_A stays 0.
- In RUN, TICK and START in the same cycle -> no decrement, state SET, RUN=0. START with all fields 0 -> stays in SET, RUN=0.
- COUNT=4'b0000, U/D presses -> all fields unchanged. U/D presses during RUN -> ignored.
